// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the memory arbiter and the main-memory RAM.
// The arbiter uses the slave modport; the requesters and RAM use the master modport.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              stall0;
    logic              stall1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              inv0;
    logic              inv1;
    logic [ADDR_W-1:0] inv_addr;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        output ack0, ack1, rdata0, rdata1, stall0, stall1,
        output mem_addr, mem_wdata, mem_rden, mem_wren, inv0, inv1, inv_addr
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        input  ack0, ack1, rdata0, rdata1, stall0, stall1,
        input  mem_addr, mem_wdata, mem_rden, mem_wren, inv0, inv1, inv_addr
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two cache controllers serialised access to one synchronous RAM.
// Optional snoop invalidate on writes is enabled by defining ARB_SNOOP_INV_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [2:0] LP_RD_LAT = 3'(MEM_RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic              r_rrLast;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_cnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_rden;
    logic              r_wren;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_anyReq;
    logic              w_grantCore;
    logic              w_grantWe;
    logic [ADDR_W-1:0] w_grantAddr;
    logic [DATA_W-1:0] w_grantWdata;

    // On a tie the core that was not served last wins, so a waiting core is never starved.
    assign w_anyReq     = bus.req0 | bus.req1;
    assign w_grantCore  = (bus.req0 & bus.req1) ? ~r_rrLast : bus.req1;
    assign w_grantWe    = w_grantCore ? bus.we1    : bus.we0;
    assign w_grantAddr  = w_grantCore ? bus.addr1  : bus.addr0;
    assign w_grantWdata = w_grantCore ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_rrLast <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_rden <= 1'b0;
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_grantCore;
                        r_we    <= w_grantWe;
                        r_addr  <= w_grantAddr;
                        r_wdata <= w_grantWdata;
                        r_rden  <= ~w_grantWe;
                        r_wren  <= w_grantWe;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= LP_RD_LAT;
                    if (r_we) begin
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_state <= S_ACK;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The last wait cycle is the one in which mem_q holds the strobed word.
                    if (r_cnt == 3'd1) begin
                        if (r_owner) begin
                            r_rdata1 <= bus.mem_q;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= bus.mem_q;
                            r_ack0   <= 1'b1;
                        end
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ACK: begin
                    r_rrLast <= r_owner;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.stall0    = bus.req0 & ~r_ack0;
    assign bus.stall1    = bus.req1 & ~r_ack1;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rden  = r_rden;
    assign bus.mem_wren  = r_wren;

`ifdef ARB_SNOOP_INV_EN
    logic              r_inv0;
    logic              r_inv1;
    logic [ADDR_W-1:0] r_invAddr;

    // Invalidate pulse lines up with the ISSUE cycle of a write and targets the other cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv0    <= 1'b0;
            r_inv1    <= 1'b0;
            r_invAddr <= '0;
        end else begin
            r_inv0 <= 1'b0;
            r_inv1 <= 1'b0;
            if (r_state == S_IDLE && w_anyReq && w_grantWe) begin
                r_inv0    <= w_grantCore;
                r_inv1    <= ~w_grantCore;
                r_invAddr <= w_grantAddr;
            end
        end
    end

    assign bus.inv0     = r_inv0;
    assign bus.inv1     = r_inv1;
    assign bus.inv_addr = r_invAddr;
`else
    assign bus.inv0     = 1'b0;
    assign bus.inv1     = 1'b0;
    assign bus.inv_addr = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a two-cycle-latency RAM model.
// Snoop expectations follow ARB_SNOOP_INV_EN.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        ramInit;
    int          checkCount;
    int          failCount;
    logic [31:0] shadowRdata [2];

    logic [31:0] ram [0:4095];
    logic [31:0] ramStage;

    logic        prevReq0, prevReq1, prevWe0, prevWe1;
    logic [11:0] prevAddr0, prevAddr1;
    logic [31:0] prevWdata0, prevWdata1;

    mem_bus_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_RD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data appears two cycles after the strobe cycle; background pattern is A5A5_<addr>.
    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'hA5A5_0000 | i;
            ram[12'h0A4] <= 32'h1234_5678;
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_rden) ramStage <= ram[bus.mem_addr];
        bus.mem_q <= ramStage;
    end

    // Requester protocol: once raised, req and its payload stay put until the ack cycle.
    always @(posedge clk) begin
        if (!rst && prevReq0 && !bus.ack0)
            assert (bus.req0 && bus.we0 == prevWe0 && bus.addr0 == prevAddr0 && bus.wdata0 == prevWdata0)
            else $error("[TB] protocol violation on core0");
        if (!rst && prevReq1 && !bus.ack1)
            assert (bus.req1 && bus.we1 == prevWe1 && bus.addr1 == prevAddr1 && bus.wdata1 == prevWdata1)
            else $error("[TB] protocol violation on core1");
        prevReq0   <= rst ? 1'b0 : bus.req0;
        prevReq1   <= rst ? 1'b0 : bus.req1;
        prevWe0    <= bus.we0;
        prevWe1    <= bus.we1;
        prevAddr0  <= bus.addr0;
        prevAddr1  <= bus.addr1;
        prevWdata0 <= bus.wdata0;
        prevWdata1 <= bus.wdata1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int core, input logic we, input logic [11:0] addr, input logic [31:0] wdata);
        if (core == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic releaseCore(input int core);
        if (core == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    // Single uncontended transaction: checks strobes in the ISSUE cycle, ack latency and rdata.
    task automatic runLone(input string tag, input int core, input logic we, input logic [11:0] addr,
                           input logic [31:0] wdata, input int expLat, input logic [31:0] expRdata);
        logic done;
        done = 1'b0;
        applyStimulus(core, we, addr, wdata);
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checkOutput({tag, " rden"}, bus.mem_rden, !we);
                checkOutput({tag, " wren"}, bus.mem_wren, we);
                checkOutput({tag, " mem_addr"}, bus.mem_addr, addr);
                if (we) checkOutput({tag, " mem_wdata"}, bus.mem_wdata, wdata);
                checkOutput({tag, " stall"}, (core == 0) ? bus.stall0 : bus.stall1, 1);
`ifdef ARB_SNOOP_INV_EN
                checkOutput({tag, " inv0"}, bus.inv0, we && core == 1);
                checkOutput({tag, " inv1"}, bus.inv1, we && core == 0);
                if (we) checkOutput({tag, " inv_addr"}, bus.inv_addr, addr);
`else
                checkOutput({tag, " inv0"}, bus.inv0, 0);
                checkOutput({tag, " inv1"}, bus.inv1, 0);
                checkOutput({tag, " inv_addr"}, bus.inv_addr, 0);
`endif
            end
            if ((core == 0) ? bus.ack1 : bus.ack0) checkOutput({tag, " stray ack"}, 1, 0);
            if ((core == 0) ? bus.ack0 : bus.ack1) begin
                done = 1'b1;
                checkOutput({tag, " latency"}, cyc, expLat);
                checkOutput({tag, " stall at ack"}, (core == 0) ? bus.stall0 : bus.stall1, 0);
                if (!we) shadowRdata[core] = expRdata;
                checkOutput({tag, " rdata0"}, bus.rdata0, shadowRdata[0]);
                checkOutput({tag, " rdata1"}, bus.rdata1, shadowRdata[1]);
                releaseCore(core);
            end
        end
        if (!done) begin
            checkOutput({tag, " timeout"}, 0, 1);
            releaseCore(core);
        end
    endtask

    // Both cores request in the same cycle, one transaction each.
    task automatic runPair(input string tag,
                           input logic we0v, input logic [11:0] a0, input logic [31:0] d0,
                           input logic we1v, input logic [11:0] a1, input logic [31:0] d1,
                           input int expCyc0, input int expCyc1,
                           input logic [31:0] expRd0, input logic [31:0] expRd1);
        int ackCyc [2];
        ackCyc = '{0, 0};
        applyStimulus(0, we0v, a0, d0);
        applyStimulus(1, we1v, a1, d1);
        for (int cyc = 1; cyc <= 40 && (ackCyc[0] == 0 || ackCyc[1] == 0); cyc++) begin
            @(negedge clk);
            if (bus.ack0 && bus.ack1) checkOutput({tag, " dual ack"}, 1, 0);
            if (bus.ack0) begin
                ackCyc[0] = cyc;
                if (!we0v) shadowRdata[0] = expRd0;
                checkOutput({tag, " rdata0 at ack0"}, bus.rdata0, shadowRdata[0]);
                checkOutput({tag, " rdata1 at ack0"}, bus.rdata1, shadowRdata[1]);
                releaseCore(0);
            end
            if (bus.ack1) begin
                ackCyc[1] = cyc;
                if (!we1v) shadowRdata[1] = expRd1;
                checkOutput({tag, " rdata1 at ack1"}, bus.rdata1, shadowRdata[1]);
                checkOutput({tag, " rdata0 at ack1"}, bus.rdata0, shadowRdata[0]);
                releaseCore(1);
            end
        end
        releaseCore(0);
        releaseCore(1);
        checkOutput({tag, " ack0 cycle"}, ackCyc[0], expCyc0);
        checkOutput({tag, " ack1 cycle"}, ackCyc[1], expCyc1);
    endtask

    // Both cores keep requesting writes back to back; grants must alternate every 3 cycles.
    task automatic runContention(input int perCore);
        int remaining [2];
        int issued [2];
        int ackOrder [$];
        int ackCycle [$];
        remaining = '{perCore, perCore};
        issued    = '{1, 1};
        applyStimulus(0, 1'b1, 12'h100, 32'h0000_1000);
        applyStimulus(1, 1'b1, 12'h200, 32'h0000_2000);
        for (int cyc = 1; cyc <= 80 && (remaining[0] + remaining[1]) > 0; cyc++) begin
            @(negedge clk);
            if (bus.ack0 && bus.ack1) checkOutput("contention dual ack", 1, 0);
            for (int c = 0; c < 2; c++) begin
                if ((c == 0) ? bus.ack0 : bus.ack1) begin
                    ackOrder.push_back(c);
                    ackCycle.push_back(cyc);
                    remaining[c]--;
                    if (remaining[c] > 0) begin
                        applyStimulus(c, 1'b1, 12'(12'h100 * (c + 1) + issued[c]), 32'(32'h1000 * (c + 1) + issued[c]));
                        issued[c]++;
                    end else begin
                        releaseCore(c);
                    end
                end
            end
        end
        releaseCore(0);
        releaseCore(1);
        checkOutput("contention ack count", ackOrder.size(), 2 * perCore);
        for (int i = 0; i < ackOrder.size() && i < 2 * perCore; i++) begin
            checkOutput($sformatf("contention grant %0d", i), ackOrder[i], i % 2);
            checkOutput($sformatf("contention ack cycle %0d", i), ackCycle[i], 3 * i + 2);
        end
        checkOutput("contention rdata0", bus.rdata0, shadowRdata[0]);
        checkOutput("contention rdata1", bus.rdata1, shadowRdata[1]);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount     = 0;
        failCount      = 0;
        shadowRdata[0] = '0;
        shadowRdata[1] = '0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst     = 1'b1;
        ramInit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ack0", bus.ack0, 0);
        checkOutput("reset ack1", bus.ack1, 0);
        checkOutput("reset rdata0", bus.rdata0, 0);
        checkOutput("reset rdata1", bus.rdata1, 0);
        checkOutput("reset mem_addr", bus.mem_addr, 0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset mem_rden", bus.mem_rden, 0);
        checkOutput("reset mem_wren", bus.mem_wren, 0);
        checkOutput("reset inv0", bus.inv0, 0);
        checkOutput("reset inv1", bus.inv1, 0);
        checkOutput("reset inv_addr", bus.inv_addr, 0);
        checkOutput("reset stall0", bus.stall0, 0);
        checkOutput("reset stall1", bus.stall1, 0);
        ramInit = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        // First tie after reset goes to core0; core1's read follows at the next IDLE.
        runPair("tie reads", 1'b0, 12'h011, 32'h0, 1'b0, 12'h022, 32'h0, 4, 9, 32'hA5A5_0011, 32'hA5A5_0022);
        @(negedge clk);

        runLone("lone read", 0, 1'b0, 12'h0A4, 32'h0, 4, 32'h1234_5678);
        @(negedge clk);
        runLone("lone write", 1, 1'b1, 12'h0A4, 32'hDEAD_BEEF, 2, 32'h0);
        @(negedge clk);

        runContention(3);
        @(negedge clk);

        // Core1 was served last, so core0's write goes first and core1 reads the new word.
        runPair("same addr", 1'b1, 12'h3FF, 32'hCAFE_0001, 1'b0, 12'h3FF, 32'h0, 2, 7, 32'h0, 32'hCAFE_0001);
        @(negedge clk);

        applyStimulus(0, 1'b0, 12'h033, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        releaseCore(0);
        #1;
        checkOutput("mid reset ack0", bus.ack0, 0);
        checkOutput("mid reset mem_rden", bus.mem_rden, 0);
        checkOutput("mid reset mem_wren", bus.mem_wren, 0);
        checkOutput("mid reset mem_addr", bus.mem_addr, 0);
        checkOutput("mid reset rdata0", bus.rdata0, 0);
        checkOutput("mid reset rdata1", bus.rdata1, 0);
        shadowRdata[0] = '0;
        shadowRdata[1] = '0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("held reset ack0", bus.ack0, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            checkOutput("post reset no ack0", bus.ack0, 0);
        end

        runLone("read after reset", 1, 1'b0, 12'h044, 32'h0, 4, 32'hA5A5_0044);
        @(negedge clk);
        runLone("snoop write", 0, 1'b1, 12'h010, 32'h5A5A_5A5A, 2, 32'h0);
        @(negedge clk);
        runLone("readback 010", 1, 1'b0, 12'h010, 32'h0, 4, 32'h5A5A_5A5A);
        @(negedge clk);
        runLone("readback 0A4", 0, 1'b0, 12'h0A4, 32'h0, 4, 32'hDEAD_BEEF);
        @(negedge clk);
        runLone("readback 101", 1, 1'b0, 12'h101, 32'h0, 4, 32'h0000_1001);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
